useq_fetch_decode: RTL and testbench
====================================

Name: useq_fetch_decode

Overview:
- Fetch/decode micro-sequencer that sits directly upstream of the register selector.
- Fetches 16-bit instruction words from memory using register 7 (PC) as the address source, latches them into an instruction register, and splits out operand fields op0/op1/op2.
- Steps a small FSM that drives the register selector's OE/load enables and source selects, plus ALU operand latch strobes.

Parameters:
- PC_REG, 7, register index used as PC for fetch address output.
- OPC_W, 7, opcode field width (ir[15:9]).

Ports:
- clock  in  1  system clock, rising edge.
- notReset  in  1  asynchronous, active-low reset.
- memData  in  16  instruction word from memory.
- memReady  in  1  memory read complete, sampled on clock.
- memRead  out  1  memory read request.
- pcInc  out  1  one-cycle PC increment pulse.
- oe  out  1  register output-enable request to the selector.
- load  out  1  register load request to the selector.
- oeSourceSel  out  2  00 = useqRegSelOE, 01 = op0, 10 = op1, 11 = op2.
- loadSourceSel  out  1  0 = useqRegSelLoad, 1 = op0.
- useqRegSelOE  out  3  microcode-selected OE register.
- useqRegSelLoad  out  3  microcode-selected load register; always 0 (unused, no microcode load target yet).
- op0, op1, op2  out  3 each  ir[8:6], ir[5:3], ir[2:0].
- aluALoad, aluBLoad  out  1  ALU operand latch strobes.
- aluResultOE  out  1  ALU result onto bus.
- aluFunc  out  1  0 = ADD, 1 = SUB; valid in EXEC1..EXEC3.
- illegal  out  1  one-cycle pulse on undefined opcode.
- halted  out  1  high in HALT.

Behaviour:
- Reset (notReset low, async): state=RST, ir=16'h0000, all outputs 0. The state is RST for the first clock edge after release; the next state is FETCH_A.
- Outputs are a Moore decode of state and ir. Every output not listed for a state is 0.
- FETCH_A (1 cycle): oe=1, oeSourceSel=00, useqRegSelOE=PC_REG, memRead=1. Next state is FETCH_W.
- FETCH_W: same outputs as FETCH_A.
  - memReady low: stay in FETCH_W, with no timeout.
  - memReady high at an edge: ir<=memData, go to DECODE.
- DECODE (1 cycle): pcInc=1. Next state depends on opcode = ir[15:9]:
  - 0x00 NOP -> FETCH_A.
  - 0x01 MOV -> EXEC1.
  - 0x02 ADD, 0x03 SUB -> EXEC1.
  - 0x7F HALT -> HALT.
  - Any other opcode: illegal=1 this cycle, then -> FETCH_A (executes as a NOP).
- MOV, EXEC1 (1 cycle): oe=1, oeSourceSel=10, load=1, loadSourceSel=1 (op0 <- op1). Then -> FETCH_A.
- ADD/SUB, EXEC1: oe=1, oeSourceSel=10, aluALoad=1.
- ADD/SUB, EXEC2: oe=1, oeSourceSel=11, aluBLoad=1.
- ADD/SUB, EXEC3: aluResultOE=1, load=1, loadSourceSel=1, oe=0. Then -> FETCH_A.
- aluFunc=ir[9] (ADD=0, SUB=1).
- HALT: halted=1, all else 0. Held until reset.
- ir changes only on the FETCH_W→DECODE edge, so op0..op2 are stable through decode and execute.
- Instruction latency: 1 + N_wait + 1 cycles for fetch/decode (N_wait = FETCH_W cycles spent waiting, ≥1), plus 0, 1 or 3 execute cycles.
- oe and load are never both sourced from the same register in one cycle. For MOV op0==op1, the simultaneous OE and load of that register is legal and left to the register file.
- Reset asserted mid-instruction aborts immediately to RST. A partially loaded ALU latch is not cleared.
- memReady outside FETCH_W is ignored.

Decomposition:
- Shared package/header holds:
  - state encodings (RST, FETCH_A, FETCH_W, DECODE, EXEC1, EXEC2, EXEC3, HALT; 3-bit);
  - opcode constants (OPC_NOP, OPC_MOV, OPC_ADD, OPC_SUB, OPC_HALT);
  - oeSourceSel codes (SEL_USEQ, SEL_OP0, SEL_OP1, SEL_OP2) and loadSourceSel codes.
- One natural sub-module: useq_out_decode, a purely combinational state+opcode → control-output decoder. The FSM and ir register stay in the top module.

Test Plan:
- Reset then release with memReady=1, memData=16'h0000: FETCH_A asserts oe=1, useqRegSelOE=7, memRead=1 → DECODE pcInc=1 → back to FETCH_A; illegal=0.
- memData=16'h0299 (MOV, op0=2, op1=3, op2=1), memReady held low 3 cycles then high: memRead stays high for 4 FETCH_W cycles. EXEC1: oe=1, oeSourceSel=10, load=1, loadSourceSel=1, op0=2, op1=3.
- memData=16'h0653 (SUB, op0=1, op1=2, op2=3):
  - EXEC1: aluALoad=1, oeSourceSel=10.
  - EXEC2: aluBLoad=1, oeSourceSel=11.
  - EXEC3: aluResultOE=1, load=1, loadSourceSel=1.
  - aluFunc=1 throughout EXEC1..EXEC3.
- memData=16'h0A00 (opcode 0x05): illegal=1 for exactly the DECODE cycle, no ALU or load strobes, next state FETCH_A.
- memData=16'hFE00 (HALT): halted=1 held for 20 cycles with memRead=0 and oe=0. notReset pulse low → halted=0 immediately (async), and FETCH_A follows release.
- Assert notReset low during EXEC2 of an ADD: all outputs 0 within the same cycle without waiting for a clock edge, and ir=0.

Source files
------------

// File: rtl/useq_fetch_decode_pkg.sv
// Shared types and constants for the fetch/decode micro-sequencer:
// state encoding, opcodes, source-select codes and the control bundle.
package useq_fetch_decode_pkg;

   localparam int IR_W = 16;

   typedef enum logic [2:0] {
      ST_RST     = 3'd0,
      ST_FETCH_A = 3'd1,
      ST_FETCH_W = 3'd2,
      ST_DECODE  = 3'd3,
      ST_EXEC1   = 3'd4,
      ST_EXEC2   = 3'd5,
      ST_EXEC3   = 3'd6,
      ST_HALT    = 3'd7
   } state_t;

   localparam logic [6:0] OPC_NOP  = 7'h00;
   localparam logic [6:0] OPC_MOV  = 7'h01;
   localparam logic [6:0] OPC_ADD  = 7'h02;
   localparam logic [6:0] OPC_SUB  = 7'h03;
   localparam logic [6:0] OPC_HALT = 7'h7F;

   localparam logic [1:0] SEL_USEQ = 2'b00;
   localparam logic [1:0] SEL_OP0  = 2'b01;
   localparam logic [1:0] SEL_OP1  = 2'b10;
   localparam logic [1:0] SEL_OP2  = 2'b11;

   localparam logic LD_USEQ = 1'b0;
   localparam logic LD_OP0  = 1'b1;

   typedef struct packed {
      logic       mem_read;
      logic       pc_inc;
      logic       oe;
      logic       load;
      logic [1:0] oe_sel;
      logic       load_sel;
      logic [2:0] sel_oe_reg;
      logic       alu_a_load;
      logic       alu_b_load;
      logic       alu_result_oe;
      logic       alu_func;
      logic       illegal;
      logic       halted;
   } ctrl_t;

   function automatic logic is_alu(input logic [6:0] opc);
      return (opc == OPC_ADD) || (opc == OPC_SUB);
   endfunction

   function automatic logic is_legal(input logic [6:0] opc);
      return (opc == OPC_NOP) || (opc == OPC_MOV) || is_alu(opc) || (opc == OPC_HALT);
   endfunction

endpackage

// File: rtl/useq_fetch_decode_if.sv
// Memory handshake and register-selector / ALU control bundle between the
// micro-sequencer (master) and its environment (slave).
interface useq_fetch_decode_if;

   logic [15:0] memData;
   logic        memReady;
   logic        memRead;
   logic        pcInc;
   logic        oe;
   logic        load;
   logic [1:0]  oeSourceSel;
   logic        loadSourceSel;
   logic [2:0]  useqRegSelOE;
   logic [2:0]  useqRegSelLoad;
   logic [2:0]  op0;
   logic [2:0]  op1;
   logic [2:0]  op2;
   logic        aluALoad;
   logic        aluBLoad;
   logic        aluResultOE;
   logic        aluFunc;
   logic        illegal;
   logic        halted;

   modport master (
      input  memData, memReady,
      output memRead, pcInc, oe, load, oeSourceSel, loadSourceSel,
             useqRegSelOE, useqRegSelLoad, op0, op1, op2,
             aluALoad, aluBLoad, aluResultOE, aluFunc, illegal, halted
   );

   modport slave (
      output memData, memReady,
      input  memRead, pcInc, oe, load, oeSourceSel, loadSourceSel,
             useqRegSelOE, useqRegSelLoad, op0, op1, op2,
             aluALoad, aluBLoad, aluResultOE, aluFunc, illegal, halted
   );

endinterface

// File: rtl/useq_fetch_decode_out_decode.sv
// Purely combinational Moore decode of sequencer state and latched opcode
// into register-selector and ALU control strobes.
module useq_out_decode
   import useq_fetch_decode_pkg::*;
#(
   parameter int PC_REG = 7,
   parameter int OPC_W  = 7
) (
   input  state_t           state,
   input  logic [OPC_W-1:0] opcode,
   output ctrl_t            ctrl
);

   always_comb begin
      ctrl          = '0;
      ctrl.oe_sel   = SEL_USEQ;
      ctrl.load_sel = LD_USEQ;
      unique case (state)
         ST_FETCH_A, ST_FETCH_W: begin
            ctrl.oe         = 1'b1;
            ctrl.sel_oe_reg = 3'(PC_REG);
            ctrl.mem_read   = 1'b1;
         end
         ST_DECODE: begin
            ctrl.pc_inc  = 1'b1;
            ctrl.illegal = !is_legal(opcode);
         end
         ST_EXEC1: begin
            ctrl.oe     = 1'b1;
            ctrl.oe_sel = SEL_OP1;
            if (opcode == OPC_MOV) begin
               ctrl.load     = 1'b1;
               ctrl.load_sel = LD_OP0;
            end else if (is_alu(opcode)) begin
               ctrl.alu_a_load = 1'b1;
               ctrl.alu_func   = opcode[0];
            end
         end
         ST_EXEC2: begin
            ctrl.oe         = 1'b1;
            ctrl.oe_sel     = SEL_OP2;
            ctrl.alu_b_load = 1'b1;
            ctrl.alu_func   = opcode[0];
         end
         // Result write-back: the bus carries the ALU, so no register OE.
         ST_EXEC3: begin
            ctrl.alu_result_oe = 1'b1;
            ctrl.load          = 1'b1;
            ctrl.load_sel      = LD_OP0;
            ctrl.alu_func      = opcode[0];
         end
         ST_HALT: ctrl.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/useq_fetch_decode.sv
// Fetch/decode micro-sequencer: fetches via the PC register, latches the
// instruction word and steps the execute FSM driving the register selector.
module useq_fetch_decode
   import useq_fetch_decode_pkg::*;
#(
   parameter int PC_REG = 7,
   parameter int OPC_W  = 7
) (
   input  logic                clock,
   input  logic                notReset,
   useq_fetch_decode_if.master bus
);

   state_t            state_q, state_d;
   logic [IR_W-1:0]   ir_q, ir_d;
   logic [OPC_W-1:0]  opcode;
   ctrl_t             ctrl;

   assign opcode = ir_q[IR_W-1 -: OPC_W];

   always_ff @(posedge clock or negedge notReset) begin
      if (!notReset) begin
         state_q <= ST_RST;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      unique case (state_q)
         ST_RST:     state_d = ST_FETCH_A;
         ST_FETCH_A: state_d = ST_FETCH_W;
         // No timeout: a memory that never answers parks the sequencer here.
         ST_FETCH_W: begin
            if (bus.memReady) begin
               ir_d    = bus.memData;
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (opcode == OPC_HALT)
               state_d = ST_HALT;
            else if ((opcode == OPC_MOV) || is_alu(opcode))
               state_d = ST_EXEC1;
            else
               state_d = ST_FETCH_A;
         end
         ST_EXEC1:   state_d = is_alu(opcode) ? ST_EXEC2 : ST_FETCH_A;
         ST_EXEC2:   state_d = ST_EXEC3;
         ST_EXEC3:   state_d = ST_FETCH_A;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_RST;
      endcase
   end

   useq_out_decode #(
      .PC_REG (PC_REG),
      .OPC_W  (OPC_W)
   ) u_out_decode (
      .state  (state_q),
      .opcode (opcode),
      .ctrl   (ctrl)
   );

   assign bus.memRead        = ctrl.mem_read;
   assign bus.pcInc          = ctrl.pc_inc;
   assign bus.oe             = ctrl.oe;
   assign bus.load           = ctrl.load;
   assign bus.oeSourceSel    = ctrl.oe_sel;
   assign bus.loadSourceSel  = ctrl.load_sel;
   assign bus.useqRegSelOE   = ctrl.sel_oe_reg;
   assign bus.useqRegSelLoad = 3'd0;
   assign bus.aluALoad       = ctrl.alu_a_load;
   assign bus.aluBLoad       = ctrl.alu_b_load;
   assign bus.aluResultOE    = ctrl.alu_result_oe;
   assign bus.aluFunc        = ctrl.alu_func;
   assign bus.illegal        = ctrl.illegal;
   assign bus.halted         = ctrl.halted;
   assign bus.op0            = ir_q[8:6];
   assign bus.op1            = ir_q[5:3];
   assign bus.op2            = ir_q[2:0];

endmodule

// File: tb/tb_useq_fetch_decode.sv
// Bench for useq_fetch_decode: each instruction is expanded into its expected
// per-cycle output sequence and compared cycle by cycle on the falling edge.
module tb_useq_fetch_decode;

   logic clock;
   logic notReset;
   int   vectors;
   int   miscompares;
   logic [15:0] ir_m;

   useq_fetch_decode_if bus ();

   useq_fetch_decode dut (
      .clock    (clock),
      .notReset (notReset),
      .bus      (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic       memRead;
      logic       pcInc;
      logic       oe;
      logic       load;
      logic [1:0] oeSel;
      logic       loadSel;
      logic [2:0] regOE;
      logic [2:0] regLoad;
      logic [2:0] op0;
      logic [2:0] op1;
      logic [2:0] op2;
      logic       aluA;
      logic       aluB;
      logic       aluRes;
      logic       aluFunc;
      logic       illegal;
      logic       halted;
   } obs_t;

   localparam int PH_ZERO   = 0;
   localparam int PH_FETCH  = 1;
   localparam int PH_DECODE = 2;
   localparam int PH_MOV    = 3;
   localparam int PH_ALU_A  = 4;
   localparam int PH_ALU_B  = 5;
   localparam int PH_ALU_R  = 6;
   localparam int PH_HALT   = 7;

   function automatic obs_t sample();
      obs_t s;
      s.memRead = bus.memRead;      s.pcInc   = bus.pcInc;
      s.oe      = bus.oe;           s.load    = bus.load;
      s.oeSel   = bus.oeSourceSel;  s.loadSel = bus.loadSourceSel;
      s.regOE   = bus.useqRegSelOE; s.regLoad = bus.useqRegSelLoad;
      s.op0     = bus.op0;          s.op1     = bus.op1;
      s.op2     = bus.op2;          s.aluA    = bus.aluALoad;
      s.aluB    = bus.aluBLoad;     s.aluRes  = bus.aluResultOE;
      s.aluFunc = bus.aluFunc;      s.illegal = bus.illegal;
      s.halted  = bus.halted;
      return s;
   endfunction

   // Expected outputs for one cycle of a given phase with instruction word w held in ir.
   function automatic obs_t exp_vec(input int ph, input logic [15:0] w);
      obs_t e = '0;
      logic [6:0] opc = w[15:9];
      e.op0 = w[8:6];
      e.op1 = w[5:3];
      e.op2 = w[2:0];
      case (ph)
         PH_FETCH: begin e.memRead = 1; e.oe = 1; e.oeSel = 2'b00; e.regOE = 3'd7; end
         PH_DECODE: begin
            e.pcInc   = 1;
            e.illegal = !(opc == 7'h00 || opc == 7'h01 || opc == 7'h02 ||
                          opc == 7'h03 || opc == 7'h7F);
         end
         PH_MOV:   begin e.oe = 1; e.oeSel = 2'b10; e.load = 1; e.loadSel = 1; end
         PH_ALU_A: begin e.oe = 1; e.oeSel = 2'b10; e.aluA = 1; e.aluFunc = (opc == 7'h03); end
         PH_ALU_B: begin e.oe = 1; e.oeSel = 2'b11; e.aluB = 1; e.aluFunc = (opc == 7'h03); end
         PH_ALU_R: begin e.aluRes = 1; e.load = 1; e.loadSel = 1; e.aluFunc = (opc == 7'h03); end
         PH_HALT:  e.halted = 1;
         default:  e = '0;
      endcase
      return e;
   endfunction

   task automatic check(input string tag, input obs_t exp);
      obs_t got = sample();
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Runs one instruction from FETCH_A; abort_at >= 0 asserts reset after that cycle's check.
   task automatic run_instr(input string tag, input logic [15:0] w,
                            input int waits, input int abort_at);
      int         ph[$];
      bit         rdy[$];
      int         ld;
      logic [6:0] opc = w[15:9];
      ph.push_back(PH_FETCH); rdy.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < waits; k++) begin ph.push_back(PH_FETCH); rdy.push_back(1'b0); end
      ph.push_back(PH_FETCH); rdy.push_back(1'b1);
      ld = ph.size() - 1;
      ph.push_back(PH_DECODE);
      if (opc == 7'h01) ph.push_back(PH_MOV);
      else if (opc == 7'h02 || opc == 7'h03) begin
         ph.push_back(PH_ALU_A); ph.push_back(PH_ALU_B); ph.push_back(PH_ALU_R);
      end
      while (rdy.size() < ph.size()) rdy.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < ph.size(); i++) begin
         bus.memReady = rdy[i];
         bus.memData  = (i == ld) ? w : 16'($urandom);
         check($sformatf("%s_c%0d", tag, i), exp_vec(ph[i], (i > ld) ? w : ir_m));
         if (i == abort_at) begin
            notReset = 1'b0;
            #1;
            check($sformatf("%s_async_rst", tag), exp_vec(PH_ZERO, 16'h0000));
            ir_m = 16'h0000;
            return;
         end
         @(posedge clock);
         @(negedge clock);
      end
      ir_m = w;
   endtask

   // Called at a falling edge with notReset low; leaves the DUT in FETCH_A.
   task automatic release_reset(input string tag);
      @(negedge clock);
      @(negedge clock);
      notReset = 1'b1;
      check($sformatf("%s_rst_state", tag), exp_vec(PH_ZERO, 16'h0000));
      @(posedge clock);
      @(negedge clock);
   endtask

   initial begin
      logic [15:0] w;
      int          sel;
      vectors      = 0;
      miscompares  = 0;
      ir_m         = 16'h0000;
      notReset     = 1'b0;
      bus.memReady = 1'b0;
      bus.memData  = 16'h0000;
      @(negedge clock);
      check("reset_held", exp_vec(PH_ZERO, 16'h0000));
      release_reset("boot");

      run_instr("nop",   16'h0000, 0, -1);
      run_instr("mov",   16'h0299, 3, -1);
      run_instr("sub",   16'h0653, 1, -1);
      run_instr("ill05", 16'h0A00, 0, -1);
      run_instr("add",   16'h04D1, 2, -1);
      run_instr("mov_same", 16'h02DB, 0, -1);

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 5);
         w   = 16'($urandom);
         case (sel)
            0: w[15:9] = 7'h00;
            1: w[15:9] = 7'h01;
            2: w[15:9] = 7'h02;
            3: w[15:9] = 7'h03;
            default: w[15:9] = 7'($urandom_range(4, 126));
         endcase
         run_instr($sformatf("rnd%0d", n), w, $urandom_range(0, 3), -1);
      end

      // Reset during EXEC2 of an ADD (waits=1 puts EXEC2 at cycle index 5).
      run_instr("add_abort", 16'h04D1, 1, 5);
      release_reset("abort");
      run_instr("post_abort", 16'h0653, 0, -1);

      run_instr("halt", 16'hFE00, 1, -1);
      for (int k = 0; k < 20; k++) begin
         bus.memReady = 1'($urandom_range(0, 1));
         bus.memData  = 16'($urandom);
         check($sformatf("halted_%0d", k), exp_vec(PH_HALT, ir_m));
         @(posedge clock);
         @(negedge clock);
      end
      notReset = 1'b0;
      #1;
      check("halt_async_rst", exp_vec(PH_ZERO, 16'h0000));
      ir_m = 16'h0000;
      release_reset("halt");
      run_instr("after_halt", 16'h0299, 0, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
